param_paritysel_demux: RTL and testbench
========================================

PARAM_PARITYSEL_DEMUX -- requirements
Module: param_paritysel_demux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, giving the per-lane transfer counter width.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port sel  input  5  lane select; sel even routes to lane A, sel odd routes to lane B.
REQ-006 Port data_in  input  WIDTH  input beat payload.
REQ-007 Port in_valid  input  1  input beat present.
REQ-008 Port in_ready  output  1  module accepts the beat this cycle.
REQ-009 Port data_a  output  WIDTH  lane A payload.
REQ-010 Port a_valid  output  1  lane A beat present.
REQ-011 Port a_ready  input  1  lane A sink accepts.
REQ-012 Port data_b  output  WIDTH  lane B payload.
REQ-013 Port b_valid  output  1  lane B beat present.
REQ-014 Port b_ready  input  1  lane B sink accepts.
REQ-015 Port cnt_a  output  CNT_WIDTH  count of completed lane A output handshakes.
REQ-016 Port cnt_b  output  CNT_WIDTH  count of completed lane B output handshakes.

Function
REQ-017 Only sel[0] SHALL determine routing: sel[0]=0 selects lane A, sel[0]=1 selects lane B. sel[4:1] SHALL be ignored.
REQ-018 Each lane SHALL hold a one-entry output register with a two-state FSM: EMPTY (valid=0) and FULL (valid=1).
REQ-019 in_ready SHALL be combinational: selected lane EMPTY, or selected lane FULL with its ready=1. in_ready SHALL be 0 while rst=1.
REQ-020 An input handshake occurs when in_valid=1 and in_ready=1 at a rising edge. data_in SHALL be captured into the selected lane, and that lane's valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-021 Lane transitions are as follows:
- EMPTY->FULL on an accepted beat.
- FULL->EMPTY on an output handshake (x_valid=1 and x_ready=1) with no accepted beat.
- FULL->FULL with the new data when an output handshake and an accepted beat occur in the same cycle. No bubble SHALL occur.
REQ-022 While x_valid=1 and x_ready=0, data_x SHALL stay stable and the lane SHALL accept no new beat.
REQ-023 A stalled lane SHALL NOT block beats routed to the other lane. The non-selected lane's state SHALL be unaffected by input activity.
REQ-024 Each beat SHALL be delivered exactly once, on exactly one lane. No beat SHALL be duplicated or dropped.
REQ-025 data_x SHALL hold its last value when the lane goes EMPTY.
REQ-026 cnt_x SHALL increment by 1 on each lane x output handshake. It SHALL wrap from 2^CNT_WIDTH-1 to 0 with no saturation or flag.
REQ-027 in_valid=0 SHALL cause no state change other than lane drains. sel and data_in SHALL be don't-care when in_valid=0.

Reset
REQ-028 When rst=1 at a rising edge, the following SHALL be set on the next cycle:
- a_valid=0 and b_valid=0.
- data_a=0 and data_b=0.
- cnt_a=0 and cnt_b=0.
- Both lanes EMPTY.
REQ-029 Reset asserted mid-operation SHALL discard held beats without output handshakes. No beat SHALL be accepted in a reset cycle.
REQ-030 After rst deasserts, in_ready SHALL be 1 for either lane, and the first beat SHALL be accepted in the first non-reset cycle.

Verification
REQ-031 Routing: sel=4, data_in=0x3C, in_valid=1, a_ready=1 -> next cycle a_valid=1, data_a=0x3C, b_valid=0. Then cnt_a=1.
REQ-032 Stall isolation: sel=7, data_in=0xA5 with b_ready=0 -> b_valid=1 and data_b=0xA5 held for 5 cycles. A second sel=1 beat -> in_ready=0. A sel=2 beat with 0x11 in the same window -> accepted, data_a=0x11.
REQ-033 Throughput: sel=1,3,5 with data 0x01,0x02,0x03 on consecutive cycles, b_ready=1 -> b_valid high for 3 consecutive cycles, data_b=0x01,0x02,0x03, in_ready=1 throughout, then cnt_b=3.
REQ-034 Simultaneous drain and fill: lane A FULL with 0x10, a_ready=1, sel=0, data_in=0x20 accepted in the same cycle -> next cycle a_valid=1, data_a=0x20, cnt_a incremented by 1.
REQ-035 Reset mid-operation: lane A FULL, a_ready=0, cnt_b=2, then rst=1 for 1 cycle -> a_valid=0, data_a=0, cnt_b=0, in_ready=0 during rst. A beat offered during rst never appears on either lane.
REQ-036 Counter wrap (CNT_WIDTH=4): 17 lane A handshakes -> cnt_a sequence ...,14,15,0,1.

Source files
------------

// File: rtl/param_paritysel_demux.sv
// Parity-select demux: one input stream is routed by sel[0] into one of two
// single-entry output lanes, each with its own handshake counter.
module param_paritysel_demux #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           sel,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     data_a,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     data_b,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b
);

    // Handshakes: a beat moves on any rising edge where valid and ready are
    // both 1; valid never depends on ready, and data is held while valid waits.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t state_a;
    lane_state_t state_b;

    logic lane_b_sel;
    logic accept;
    logic take_a;
    logic take_b;
    logic drain_a;
    logic drain_b;
    logic unused_sel;

    assign lane_b_sel = sel[0];
    assign unused_sel = ^sel[4:1];

    assign a_valid = (state_a == FULL);
    assign b_valid = (state_b == FULL);

    // A full lane can still take a beat when its sink drains it in the same edge.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (lane_b_sel)
                in_ready = (state_b == EMPTY) || b_ready;
            else
                in_ready = (state_a == EMPTY) || a_ready;
        end
    end

    assign accept  = in_valid && in_ready;
    assign take_a  = accept && !lane_b_sel;
    assign take_b  = accept && lane_b_sel;
    assign drain_a = a_valid && a_ready;
    assign drain_b = b_valid && b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_a <= EMPTY;
            data_a  <= '0;
            cnt_a   <= '0;
        end else begin
            if (drain_a)
                cnt_a <= cnt_a + CNT_WIDTH'(1);
            case (state_a)
                EMPTY: begin
                    if (take_a) begin
                        data_a  <= data_in;
                        state_a <= FULL;
                    end
                end
                FULL: begin
                    if (take_a)
                        data_a <= data_in;
                    else if (a_ready)
                        state_a <= EMPTY;
                end
                default: state_a <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_b <= EMPTY;
            data_b  <= '0;
            cnt_b   <= '0;
        end else begin
            if (drain_b)
                cnt_b <= cnt_b + CNT_WIDTH'(1);
            case (state_b)
                EMPTY: begin
                    if (take_b) begin
                        data_b  <= data_in;
                        state_b <= FULL;
                    end
                end
                FULL: begin
                    if (take_b)
                        data_b <= data_in;
                    else if (b_ready)
                        state_b <= EMPTY;
                end
                default: state_b <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_param_paritysel_demux.sv
// Bench for param_paritysel_demux: directed scenario tasks plus a per-lane
// expected-data queue checked whenever a lane completes an output handshake.
module tb_param_paritysel_demux;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    sel;
    logic [W-1:0]  data_in;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data_a;
    logic          a_valid;
    logic          a_ready;
    logic [W-1:0]  data_b;
    logic          b_valid;
    logic          b_ready;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];

    param_paritysel_demux #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .sel(sel), .data_in(data_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_a(data_a), .a_valid(a_valid), .a_ready(a_ready),
        .data_b(data_b), .b_valid(b_valid), .b_ready(b_ready),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    // scoreboard: inputs are driven 1 time unit after posedge, so the negedge
    // sees exactly what the next posedge will act on
    always @(negedge clk) begin
        if (rst) begin
            exp_a_q.delete();
            exp_b_q.delete();
        end else begin
            if (a_valid && a_ready) begin
                total++;
                if (exp_a_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_a_extra got=%0h required=none", data_a);
                end else begin
                    if (data_a !== exp_a_q[0]) begin
                        bad++;
                        $display("FAIL sb_a_data got=%0h required=%0h", data_a, exp_a_q[0]);
                    end
                    void'(exp_a_q.pop_front());
                end
            end
            if (b_valid && b_ready) begin
                total++;
                if (exp_b_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_b_extra got=%0h required=none", data_b);
                end else begin
                    if (data_b !== exp_b_q[0]) begin
                        bad++;
                        $display("FAIL sb_b_data got=%0h required=%0h", data_b, exp_b_q[0]);
                    end
                    void'(exp_b_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                if (sel[0]) exp_b_q.push_back(data_in);
                else        exp_a_q.push_back(data_in);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; sel = 5'd0; data_in = 8'hEE; in_valid = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        step(); step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b required=0", in_ready); end
        total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b%0b required=00", a_valid, b_valid); end
        total++; if (data_a !== 8'h00 || data_b !== 8'h00) begin bad++; $display("FAIL rst_data got=%0h/%0h required=0/0", data_a, data_b); end
        total++; if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d required=0/0", cnt_a, cnt_b); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready_a got=%0b required=1", in_ready); end
        sel = 5'd1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready_b got=%0b required=1", in_ready); end
    endtask

    task automatic test_routing();
        sel = 5'd4; data_in = 8'h3C; in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL route_ready got=%0b required=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (a_valid !== 1'b1 || data_a !== 8'h3C || b_valid !== 1'b0) begin
            bad++; $display("FAIL route_out got=a%0b/%0h b%0b required=a1/3c b0", a_valid, data_a, b_valid); end
        step();
        total++; if (cnt_a !== 4'd1) begin bad++; $display("FAIL route_cnt got=%0d required=1", cnt_a); end
        total++; if (a_valid !== 1'b0 || data_a !== 8'h3C) begin bad++; $display("FAIL route_hold got=%0b/%0h required=0/3c", a_valid, data_a); end
    endtask

    task automatic test_stall();
        b_ready = 1'b0; a_ready = 1'b1;
        sel = 5'd7; data_in = 8'hA5; in_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b0;
            total++; if (b_valid !== 1'b1 || data_b !== 8'hA5) begin
                bad++; $display("FAIL stall_hold[%0d] got=%0b/%0h required=1/a5", i, b_valid, data_b); end
            if (i == 3) begin
                total++; if (a_valid !== 1'b1 || data_a !== 8'h11) begin
                    bad++; $display("FAIL stall_other got=%0b/%0h required=1/11", a_valid, data_a); end
            end
            if (i == 1) begin
                sel = 5'd1; data_in = 8'h55; in_valid = 1'b1; #1;
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_block got=%0b required=0", in_ready); end
            end else if (i == 2) begin
                sel = 5'd2; data_in = 8'h11; in_valid = 1'b1; #1;
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_pass got=%0b required=1", in_ready); end
            end
            step();
        end
        in_valid = 1'b0; b_ready = 1'b1;
        step();
        total++; if (b_valid !== 1'b0 || cnt_b !== 4'd1) begin
            bad++; $display("FAIL stall_release got=%0b/%0d required=0/1", b_valid, cnt_b); end
        total++; if (cnt_a !== 4'd2) begin bad++; $display("FAIL stall_cnt_a got=%0d required=2", cnt_a); end
    endtask

    task automatic test_throughput();
        do_reset();
        b_ready = 1'b1; a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = 5'(2 * i + 1); data_in = 8'(i + 1); in_valid = 1'b1;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL thr_ready[%0d] got=%0b required=1", i, in_ready); end
            step();
            total++; if (b_valid !== 1'b1 || data_b !== 8'(i + 1)) begin
                bad++; $display("FAIL thr_out[%0d] got=%0b/%0h required=1/%0h", i, b_valid, data_b, i + 1); end
        end
        in_valid = 1'b0;
        step();
        total++; if (b_valid !== 1'b0 || cnt_b !== 4'd3) begin
            bad++; $display("FAIL thr_end got=%0b/%0d required=0/3", b_valid, cnt_b); end
    endtask

    task automatic test_drain_fill();
        do_reset();
        a_ready = 1'b0; sel = 5'd0; data_in = 8'h10; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (a_valid !== 1'b1 || data_a !== 8'h10) begin bad++; $display("FAIL df_fill got=%0b/%0h required=1/10", a_valid, data_a); end
        a_ready = 1'b1; data_in = 8'h20; in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL df_ready got=%0b required=1", in_ready); end
        step();
        in_valid = 1'b0; a_ready = 1'b0;
        total++; if (a_valid !== 1'b1 || data_a !== 8'h20 || cnt_a !== 4'd1) begin
            bad++; $display("FAIL df_swap got=%0b/%0h/%0d required=1/20/1", a_valid, data_a, cnt_a); end
        a_ready = 1'b1;
        step();
        total++; if (a_valid !== 1'b0 || cnt_a !== 4'd2) begin bad++; $display("FAIL df_drain got=%0b/%0d required=0/2", a_valid, cnt_a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b_ready = 1'b1; a_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sel = 5'd1; data_in = 8'(8'h61 + i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        total++; if (cnt_b !== 4'd2) begin bad++; $display("FAIL rm_cnt_b got=%0d required=2", cnt_b); end
        sel = 5'd0; data_in = 8'h77; in_valid = 1'b1;
        step();
        total++; if (a_valid !== 1'b1 || data_a !== 8'h77) begin bad++; $display("FAIL rm_full got=%0b/%0h required=1/77", a_valid, data_a); end
        rst = 1'b1; sel = 5'd1; data_in = 8'h99; in_valid = 1'b1; a_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_ready got=%0b required=0", in_ready); end
        step();
        rst = 1'b0; in_valid = 1'b0;
        total++; if (a_valid !== 1'b0 || data_a !== 8'h00 || b_valid !== 1'b0) begin
            bad++; $display("FAIL rm_clear got=a%0b/%0h b%0b required=a0/0 b0", a_valid, data_a, b_valid); end
        total++; if (cnt_b !== 4'd0 || cnt_a !== 4'd0) begin bad++; $display("FAIL rm_cnt got=%0d/%0d required=0/0", cnt_a, cnt_b); end
        step(); step();
        total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL rm_ghost got=%0b%0b required=00", a_valid, b_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        a_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            sel = 5'($urandom_range(0, 15) * 2); data_in = 8'(k); in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            total++; if (cnt_a !== 4'((k + 1) % 16)) begin
                bad++; $display("FAIL wrap[%0d] got=%0d required=%0d", k, cnt_a, (k + 1) % 16); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            sel      = 5'($urandom_range(0, 31));
            data_in  = 8'($urandom_range(0, 255));
            in_valid = 1'($urandom_range(0, 3) != 0);
            a_ready  = 1'($urandom_range(0, 2) != 0);
            b_ready  = 1'($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        step(); step(); step();
        total++; if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            bad++; $display("FAIL b2b_left got=%0d/%0d required=0/0", exp_a_q.size(), exp_b_q.size()); end
        total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b%0b required=00", a_valid, b_valid); end
    endtask

    initial begin
        rst = 1'b1; sel = '0; data_in = '0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        test_reset();
        test_routing();
        test_stall();
        test_throughput();
        test_drain_fill();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
